// File: rtl/mport_arbiter.sv
// mport_arbiter
//   Round-robin arbiter sharing one memory-port manager between NUM_REQ clients.
//   The winner's request (enables, address, store data) is latched when it is
//   granted and held on the mp_* outputs until the transaction completes, so the
//   downstream sees stable inputs even if clients change theirs. Completion and
//   load data are returned to the granted client only. One transaction in flight.
//
// Ports
//   clk, rst_l             clock, asynchronous active-low reset
//   req_w_en / req_r_en    per-client write / read requests (write wins if both)
//   req_ptr / req_wdata    per-client address / store data, client i at [i*W +: W]
//   req_done               per-client completion, only the granted bit can be set
//   req_rdata              load data, valid while the client's req_done is high
//   mp_w_en / mp_r_en      downstream enables
//   mp_ptr / mp_wdata      downstream address / store data
//   mp_rdata / mp_done     downstream load data and done (held until enables drop)
//   grant_id               index of the current or last granted client
//   busy                   high whenever a transaction is in progress
module mport_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 32,
  parameter int GID_W   = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic [NUM_REQ-1:0]         req_w_en,
  input  logic [NUM_REQ-1:0]         req_r_en,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_ptr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [DATA_W-1:0]          req_rdata,
  output logic                       mp_w_en,
  output logic                       mp_r_en,
  output logic [ADDR_W-1:0]          mp_ptr,
  output logic [DATA_W-1:0]          mp_wdata,
  input  logic [DATA_W-1:0]          mp_rdata,
  input  logic                       mp_done,
  output logic [GID_W-1:0]           grant_id,
  output logic                       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [GID_W-1:0]    rr_q, rr_d;
  logic [GID_W-1:0]    grant_id_q, grant_id_d;
  logic                mp_w_en_q, mp_w_en_d;
  logic                mp_r_en_q, mp_r_en_d;
  logic [ADDR_W-1:0]   mp_ptr_q, mp_ptr_d;
  logic [DATA_W-1:0]   mp_wdata_q, mp_wdata_d;
  logic [NUM_REQ-1:0]  req_done_q, req_done_d;
  logic [DATA_W-1:0]   req_rdata_q, req_rdata_d;

  logic [NUM_REQ-1:0]  req_any;
  logic                win_valid;
  logic [GID_W-1:0]    win_id;
  logic [GID_W-1:0]    rr_next;

  assign req_any = req_w_en | req_r_en;

  // Search downward from the farthest offset so the requester closest to
  // (at or after) the round-robin pointer is the last one assigned and wins.
  always_comb begin
    int idx;
    idx       = 0;
    win_valid = 1'b0;
    win_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (req_any[idx]) begin
        win_valid = 1'b1;
        win_id    = GID_W'(idx);
      end
    end
  end

  // Explicit wrap so non-power-of-two NUM_REQ works too.
  assign rr_next = (grant_id_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_id_d  = grant_id_q;
    mp_w_en_d   = mp_w_en_q;
    mp_r_en_d   = mp_r_en_q;
    mp_ptr_d    = mp_ptr_q;
    mp_wdata_d  = mp_wdata_q;
    req_done_d  = req_done_q;
    req_rdata_d = req_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          grant_id_d = win_id;
          mp_ptr_d   = req_ptr[int'(win_id)*ADDR_W +: ADDR_W];
          mp_wdata_d = req_wdata[int'(win_id)*DATA_W +: DATA_W];
          mp_w_en_d  = req_w_en[win_id];
          mp_r_en_d  = req_r_en[win_id] & ~req_w_en[win_id];
          state_d    = S_GRANT;
        end
      end

      S_GRANT: begin
        if (mp_done) begin
          req_rdata_d = mp_rdata;
          if (req_any[grant_id_q]) begin
            req_done_d             = '0;
            req_done_d[grant_id_q] = 1'b1;
            state_d                = S_HOLD;
          end else begin
            // Client gave up: discard the result and let the downstream finish.
            mp_w_en_d = 1'b0;
            mp_r_en_d = 1'b0;
            state_d   = S_RELEASE;
          end
        end
      end

      S_HOLD: begin
        if (!req_any[grant_id_q]) begin
          req_done_d = '0;
          mp_w_en_d  = 1'b0;
          mp_r_en_d  = 1'b0;
          state_d    = S_RELEASE;
        end
      end

      S_RELEASE: begin
        if (!mp_done) begin
          rr_d    = rr_next;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      grant_id_q  <= '0;
      mp_w_en_q   <= 1'b0;
      mp_r_en_q   <= 1'b0;
      mp_ptr_q    <= '0;
      mp_wdata_q  <= '0;
      req_done_q  <= '0;
      req_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_id_q  <= grant_id_d;
      mp_w_en_q   <= mp_w_en_d;
      mp_r_en_q   <= mp_r_en_d;
      mp_ptr_q    <= mp_ptr_d;
      mp_wdata_q  <= mp_wdata_d;
      req_done_q  <= req_done_d;
      req_rdata_q <= req_rdata_d;
    end
  end

  assign req_done  = req_done_q;
  assign req_rdata = req_rdata_q;
  assign mp_w_en   = mp_w_en_q;
  assign mp_r_en   = mp_r_en_q;
  assign mp_ptr    = mp_ptr_q;
  assign mp_wdata  = mp_wdata_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mport_arbiter.sv
// tb_mport_arbiter
//   Directed bench for mport_arbiter. The bench plays both the clients and the
//   downstream memory-port manager. Inputs change and outputs are sampled on the
//   falling clock edge, away from the rising edge the DUT uses.
module tb_mport_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 26;
  localparam int DATA_W  = 32;
  localparam int GID_W   = 2;

  logic                      clk;
  logic                      rst_l;
  logic [NUM_REQ-1:0]        req_w_en;
  logic [NUM_REQ-1:0]        req_r_en;
  logic [NUM_REQ*ADDR_W-1:0] req_ptr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_done;
  logic [DATA_W-1:0]         req_rdata;
  logic                      mp_w_en;
  logic                      mp_r_en;
  logic [ADDR_W-1:0]         mp_ptr;
  logic [DATA_W-1:0]         mp_wdata;
  logic [DATA_W-1:0]         mp_rdata;
  logic                      mp_done;
  logic [GID_W-1:0]          grant_id;
  logic                      busy;

  int checks = 0;
  int errors = 0;

  mport_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .req_w_en  (req_w_en),
    .req_r_en  (req_r_en),
    .req_ptr   (req_ptr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_rdata (req_rdata),
    .mp_w_en   (mp_w_en),
    .mp_r_en   (mp_r_en),
    .mp_ptr    (mp_ptr),
    .mp_wdata  (mp_wdata),
    .mp_rdata  (mp_rdata),
    .mp_done   (mp_done),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input logic w, input logic r,
                               input logic [ADDR_W-1:0] p, input logic [DATA_W-1:0] d);
    req_w_en[i]                = w;
    req_r_en[i]                = r;
    req_ptr[i*ADDR_W +: ADDR_W] = p;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req_done"},  64'(req_done),  64'h0);
    checkOutput({tag, "_req_rdata"}, 64'(req_rdata), 64'h0);
    checkOutput({tag, "_mp_w_en"},   64'(mp_w_en),   64'h0);
    checkOutput({tag, "_mp_r_en"},   64'(mp_r_en),   64'h0);
    checkOutput({tag, "_mp_ptr"},    64'(mp_ptr),    64'h0);
    checkOutput({tag, "_mp_wdata"},  64'(mp_wdata),  64'h0);
    checkOutput({tag, "_grant_id"},  64'(grant_id),  64'h0);
    checkOutput({tag, "_busy"},      64'(busy),      64'h0);
  endtask

  task automatic waitBusy(input string tag);
    int n;
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_busy_wait"}, 64'(busy), 64'h1);
  endtask

  initial begin
    int exp_g[4];
    exp_g = '{0, 1, 3, 0};

    rst_l     = 1'b0;
    req_w_en  = '0;
    req_r_en  = '0;
    req_ptr   = '0;
    req_wdata = '0;
    mp_rdata  = '0;
    mp_done   = 1'b0;

    // Reset state
    tick();
    checkAllZero("reset");
    rst_l = 1'b1;
    tick();

    // Client 2 read with 5-cycle downstream latency
    applyStimulus(2, 1'b0, 1'b1, 26'h000040, 32'h0);
    #1;
    checkOutput("t1_no_comb_r_en", 64'(mp_r_en), 64'h0);
    tick();
    checkOutput("t1_mp_r_en",   64'(mp_r_en),  64'h1);
    checkOutput("t1_mp_w_en",   64'(mp_w_en),  64'h0);
    checkOutput("t1_mp_ptr",    64'(mp_ptr),   64'h40);
    checkOutput("t1_grant_id",  64'(grant_id), 64'h2);
    checkOutput("t1_busy",      64'(busy),     64'h1);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("t1_no_early_done", 64'(req_done), 64'h0);
    mp_done  = 1'b1;
    mp_rdata = 32'hDEADBEEF;
    tick();
    checkOutput("t1_req_done",  64'(req_done),  64'h4);
    checkOutput("t1_req_rdata", 64'(req_rdata), 64'hDEADBEEF);
    applyStimulus(2, 1'b0, 1'b0, 26'h000040, 32'h0);
    tick();
    checkOutput("t1_done_clear", 64'(req_done), 64'h0);
    checkOutput("t1_r_en_clear", 64'(mp_r_en),  64'h0);
    checkOutput("t1_release_busy", 64'(busy),   64'h1);
    mp_done = 1'b0;
    tick();
    checkOutput("t1_idle", 64'(busy), 64'h0);

    // Client 3 aborts before downstream completes
    applyStimulus(3, 1'b0, 1'b1, 26'h000100, 32'h0);
    tick();
    checkOutput("t4_grant_id", 64'(grant_id), 64'h3);
    applyStimulus(3, 1'b0, 1'b0, 26'h000100, 32'h0);
    tick();
    checkOutput("t4_r_en_held", 64'(mp_r_en), 64'h1);
    mp_done  = 1'b1;
    mp_rdata = 32'h0BADF00D;
    tick();
    checkOutput("t4_no_done",    64'(req_done), 64'h0);
    checkOutput("t4_r_en_drop",  64'(mp_r_en),  64'h0);
    checkOutput("t4_busy_wait",  64'(busy),     64'h1);
    tick();
    checkOutput("t4_busy_still", 64'(busy),     64'h1);
    mp_done = 1'b0;
    tick();
    checkOutput("t4_idle", 64'(busy), 64'h0);

    // Clients 0,1,3 keep requesting: grants rotate 0,1,3,0
    applyStimulus(0, 1'b0, 1'b1, 26'h000010, 32'h0);
    applyStimulus(1, 1'b0, 1'b1, 26'h000011, 32'h0);
    applyStimulus(3, 1'b0, 1'b1, 26'h000013, 32'h0);
    for (int k = 0; k < 4; k++) begin
      waitBusy($sformatf("t2_%0d", k));
      checkOutput($sformatf("t2_grant_%0d", k), 64'(grant_id), 64'(exp_g[k]));
      tick();
      tick();
      mp_done  = 1'b1;
      mp_rdata = 32'hA0 + 32'(k);
      tick();
      checkOutput($sformatf("t2_done_%0d", k),  64'(req_done),  64'(1 << exp_g[k]));
      checkOutput($sformatf("t2_rdata_%0d", k), 64'(req_rdata), 64'(32'hA0 + 32'(k)));
      req_r_en[exp_g[k]] = 1'b0;
      tick();
      checkOutput($sformatf("t2_done_clr_%0d", k), 64'(req_done), 64'h0);
      mp_done = 1'b0;
      req_r_en[exp_g[k]] = 1'b1;
      tick();
    end
    req_r_en = '0;

    // Client 1 write latched while client 0 and client 1 inputs wander
    applyStimulus(1, 1'b1, 1'b0, 26'h2000000, 32'h12345678);
    applyStimulus(0, 1'b0, 1'b1, 26'h0000111, 32'h0000AAAA);
    tick();
    checkOutput("t3_grant_id", 64'(grant_id), 64'h1);
    checkOutput("t3_mp_w_en",  64'(mp_w_en),  64'h1);
    checkOutput("t3_mp_r_en",  64'(mp_r_en),  64'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'(i[0]), 1'b1, 26'(32'h0000222 + i), 32'h5555_0000 + 32'(i));
      req_ptr[1*ADDR_W +: ADDR_W] = 26'(32'h0000333 + i);
      tick();
      checkOutput($sformatf("t3_mp_ptr_%0d", i),   64'(mp_ptr),   64'h2000000);
      checkOutput($sformatf("t3_mp_wdata_%0d", i), 64'(mp_wdata), 64'h12345678);
    end
    mp_done = 1'b1;
    tick();
    checkOutput("t3_req_done", 64'(req_done), 64'h2);
    checkOutput("t3_w_en_hold", 64'(mp_w_en), 64'h1);
    req_w_en = '0;
    req_r_en = '0;
    tick();
    checkOutput("t3_w_en_drop", 64'(mp_w_en), 64'h0);
    mp_done = 1'b0;
    tick();

    // mp_done while idle has no effect
    mp_done = 1'b1;
    tick();
    checkOutput("idle_done_busy",     64'(busy),     64'h0);
    checkOutput("idle_done_req_done", 64'(req_done), 64'h0);
    mp_done = 1'b0;
    tick();

    // Both enables set on client 0: write wins
    applyStimulus(0, 1'b1, 1'b1, 26'h0000055, 32'h0000CAFE);
    tick();
    checkOutput("t6_grant_id", 64'(grant_id), 64'h0);
    checkOutput("t6_mp_w_en",  64'(mp_w_en),  64'h1);
    checkOutput("t6_mp_r_en",  64'(mp_r_en),  64'h0);
    checkOutput("t6_mp_wdata", 64'(mp_wdata), 64'hCAFE);
    mp_done = 1'b1;
    tick();
    checkOutput("t6_req_done", 64'(req_done), 64'h1);
    applyStimulus(0, 1'b0, 1'b0, 26'h0, 32'h0);
    tick();
    mp_done = 1'b0;
    tick();

    // Reset in HOLD, then pointer must be back at 0
    applyStimulus(1, 1'b0, 1'b1, 26'h0000077, 32'h0);
    tick();
    checkOutput("t5_grant_id", 64'(grant_id), 64'h1);
    mp_done  = 1'b1;
    mp_rdata = 32'h5A5A5A5A;
    tick();
    checkOutput("t5_hold_done", 64'(req_done), 64'h2);
    #2;
    rst_l = 1'b0;
    #1;
    checkAllZero("t5_async_reset");
    req_w_en = '0;
    req_r_en = '0;
    mp_done  = 1'b0;
    tick();
    tick();
    rst_l = 1'b1;
    applyStimulus(2, 1'b0, 1'b1, 26'h0000002, 32'h0);
    applyStimulus(0, 1'b0, 1'b1, 26'h0000009, 32'h0);
    tick();
    checkOutput("t5_grant_after_reset", 64'(grant_id), 64'h0);
    checkOutput("t5_mp_ptr",            64'(mp_ptr),   64'h9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
